// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter between the program loader and the CPU.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        CPU_RD      = 3'd2,
        CPU_RD_WAIT = 3'd3,
        CPU_WR      = 3'd4
    } arb_state_t;

    localparam int          NUM_BYTES_DEFAULT = 15;
    localparam logic [15:0] BASE_ADDR_DEFAULT = 16'h0000;

    // Byte-counter width; a one-byte image still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/load_image_buffer.sv
// Shadow copy of the load image, captured on a load request, with a byte mux
// indexed by the loader's byte counter.
module load_image_buffer #(
    parameter int NUM_BYTES = 15,
    parameter int DATA_W    = 8,
    parameter int SEL_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        capture,
    input  logic [NUM_BYTES*DATA_W-1:0] image,
    input  logic [SEL_W-1:0]            sel,
    output logic [DATA_W-1:0]           byte_out
);

    logic [NUM_BYTES*DATA_W-1:0] shadow_reg;
    logic [DATA_W-1:0]           byte_table [0:(2**SEL_W)-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg <= '0;
        end else if (capture) begin
            shadow_reg <= image;
        end
    end

    // Table is padded to a power of two so every counter value has a defined byte.
    generate
        for (genvar gi = 0; gi < (2**SEL_W); gi++) begin : gen_byte
            if (gi < NUM_BYTES) begin : gen_real
                assign byte_table[gi] = shadow_reg[gi*DATA_W +: DATA_W];
            end else begin : gen_pad
                assign byte_table[gi] = '0;
            end
        end
    endgenerate

    assign byte_out = byte_table[sel];

endmodule

// File: rtl/mem_load_arbiter.sv
// Owns the single memory port: bulk image load on a loadMem rising edge, otherwise
// one CPU read or write per request/grant handshake.
module mem_load_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                NUM_BYTES = NUM_BYTES_DEFAULT,
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEFAULT)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        loadMem,
    input  logic [NUM_BYTES*DATA_W-1:0] initial_memory,
    input  logic                        cpu_req,
    input  logic                        cpu_write,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_wdata,
    output logic                        cpu_gnt,
    output logic [DATA_W-1:0]           cpu_rdata,
    output logic                        cpu_hold,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_read,
    output logic                        mem_write,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        loadMemComplete
);

    localparam int               CNT_W     = cnt_width(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    arb_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              pending_reg, pending_next;
    logic              complete_reg, complete_next;
    logic              load_prev_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              load_edge;
    logic              capture;
    logic [DATA_W-1:0] image_byte;

    // An edge that lands while a load is already running is dropped entirely.
    assign load_edge = loadMem & ~load_prev_reg;
    assign capture   = load_edge && (state_reg != LOAD);

    load_image_buffer #(
        .NUM_BYTES (NUM_BYTES),
        .DATA_W    (DATA_W),
        .SEL_W     (CNT_W)
    ) u_image (
        .clk      (clock),
        .rst      (reset),
        .capture  (capture),
        .image    (initial_memory),
        .sel      (count_reg),
        .byte_out (image_byte)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            pending_reg   <= 1'b0;
            complete_reg  <= 1'b0;
            load_prev_reg <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            pending_reg   <= pending_next;
            complete_reg  <= complete_next;
            load_prev_reg <= loadMem;
            if (state_reg == CPU_RD_WAIT) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        pending_next  = pending_reg | capture;
        complete_next = capture ? 1'b0 : complete_reg;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        cpu_gnt       = 1'b0;

        case (state_reg)
            IDLE: begin
                // A same-cycle edge counts as pending so the load beats a waiting CPU request.
                if (pending_reg || capture) begin
                    state_next = LOAD;
                end else if (cpu_req) begin
                    state_next = cpu_write ? CPU_WR : CPU_RD;
                end
            end
            LOAD: begin
                mem_write = 1'b1;
                mem_addr  = BASE_ADDR + ADDR_W'(count_reg);
                mem_wdata = image_byte;
                if (count_reg == LAST_BYTE) begin
                    count_next    = '0;
                    pending_next  = 1'b0;
                    complete_next = 1'b1;
                    state_next    = IDLE;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            CPU_WR: begin
                mem_write  = 1'b1;
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
                cpu_gnt    = 1'b1;
                state_next = IDLE;
            end
            CPU_RD: begin
                mem_read   = 1'b1;
                mem_addr   = cpu_addr;
                state_next = CPU_RD_WAIT;
            end
            CPU_RD_WAIT: begin
                cpu_gnt    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read data passes straight through in the grant cycle and is held afterwards.
    assign cpu_rdata       = (state_reg == CPU_RD_WAIT) ? mem_rdata : rdata_reg;
    assign cpu_hold        = pending_reg;
    assign loadMemComplete = complete_reg;

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Directed bench for mem_load_arbiter: loads, CPU accesses, load/CPU collisions,
// reset abort, and address wrap with a snapshot check on a second instance.
module tb_mem_load_arbiter;

    localparam int NB = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    always #5 clock = ~clock;

    // Instance A: default base address, backed by a memory model.
    logic          load_mem = 1'b0;
    logic [NB*8-1:0] image_a = '0;
    logic          cpu_req = 1'b0;
    logic          cpu_write = 1'b0;
    logic [15:0]   cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic          cpu_gnt;
    logic [7:0]    cpu_rdata;
    logic          cpu_hold;
    logic [15:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [7:0]    mem_rdata = 8'h00;
    logic          load_done;

    // Instance B: base address near the top of the address space.
    logic          load_mem_b = 1'b0;
    logic [NB*8-1:0] image_b = '0;
    logic          cpu_req_b = 1'b0;
    logic          cpu_write_b = 1'b0;
    logic [15:0]   cpu_addr_b = '0;
    logic [7:0]    cpu_wdata_b = '0;
    logic          cpu_gnt_b;
    logic [7:0]    cpu_rdata_b;
    logic          cpu_hold_b;
    logic [15:0]   mem_addr_b;
    logic [7:0]    mem_wdata_b;
    logic          mem_read_b;
    logic          mem_write_b;
    logic [7:0]    mem_rdata_b = 8'h00;
    logic          load_done_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_model [0:65535];

    always @(posedge clock) begin
        if (mem_write) mem_model[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem_model[mem_addr];
    end

    mem_load_arbiter #(.NUM_BYTES(NB), .ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'h0000)) dut (
        .clock(clock), .reset(reset), .loadMem(load_mem), .initial_memory(image_a),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .loadMemComplete(load_done)
    );

    mem_load_arbiter #(.NUM_BYTES(NB), .ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'hFFF8)) dut_b (
        .clock(clock), .reset(reset), .loadMem(load_mem_b), .initial_memory(image_b),
        .cpu_req(cpu_req_b), .cpu_write(cpu_write_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
        .cpu_gnt(cpu_gnt_b), .cpu_rdata(cpu_rdata_b), .cpu_hold(cpu_hold_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_rdata(mem_rdata_b), .loadMemComplete(load_done_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_a(input logic [7:0] first);
        for (int i = 0; i < NB; i++) image_a[i*8 +: 8] = first + 8'(i);
    endtask

    // Called in the first LOAD cycle; walks all image writes and leaves the bench in the following IDLE cycle.
    task automatic run_load_a(input string name, input logic [7:0] first);
        logic [7:0] exp_data;
        for (int k = 0; k < NB; k++) begin
            exp_data = first + 8'(k);
            chk($sformatf("%s write k=%0d", name, k), {15'd0, mem_write}, 16'd1);
            chk($sformatf("%s addr k=%0d", name, k), mem_addr, 16'(k));
            chk($sformatf("%s data k=%0d", name, k), {8'd0, mem_wdata}, {8'd0, exp_data});
            chk($sformatf("%s read k=%0d", name, k), {15'd0, mem_read}, 16'd0);
            chk($sformatf("%s hold k=%0d", name, k), {15'd0, cpu_hold}, 16'd1);
            chk($sformatf("%s gnt k=%0d", name, k), {15'd0, cpu_gnt}, 16'd0);
            chk($sformatf("%s done k=%0d", name, k), {15'd0, load_done}, 16'd0);
            tick();
        end
        chk({name, " done after"}, {15'd0, load_done}, 16'd1);
        chk({name, " hold after"}, {15'd0, cpu_hold}, 16'd0);
        chk({name, " write after"}, {15'd0, mem_write}, 16'd0);
        $display("load %s complete: %0d bytes from %h", name, NB, first);
    endtask

    initial begin
        logic [7:0]  exp_b;
        logic [15:0] exp_addr_b;

        // Reset state
        #3;
        chk("rst gnt", {15'd0, cpu_gnt}, 16'd0);
        chk("rst hold", {15'd0, cpu_hold}, 16'd0);
        chk("rst write", {15'd0, mem_write}, 16'd0);
        chk("rst read", {15'd0, mem_read}, 16'd0);
        chk("rst addr", mem_addr, 16'd0);
        chk("rst rdata", {8'd0, cpu_rdata}, 16'd0);
        chk("rst done", {15'd0, load_done}, 16'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: basic load of 10..1E
        fill_a(8'h10);
        load_mem = 1'b1;
        tick();
        load_mem = 1'b0;
        run_load_a("t1", 8'h10);

        // 2: CPU write then read back
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'hA5;
        tick();
        chk("t2 wr strobe", {15'd0, mem_write}, 16'd1);
        chk("t2 wr addr", mem_addr, 16'h0020);
        chk("t2 wr data", {8'd0, mem_wdata}, 16'h00A5);
        chk("t2 wr gnt", {15'd0, cpu_gnt}, 16'd1);
        $display("cpu write addr=%h data=%h", cpu_addr, cpu_wdata);
        cpu_req = 1'b0;
        tick();
        chk("t2 idle gnt", {15'd0, cpu_gnt}, 16'd0);
        chk("t2 idle addr", mem_addr, 16'd0);
        cpu_req = 1'b1; cpu_write = 1'b0;
        tick();
        chk("t2 rd strobe", {15'd0, mem_read}, 16'd1);
        chk("t2 rd nowrite", {15'd0, mem_write}, 16'd0);
        chk("t2 rd addr", mem_addr, 16'h0020);
        chk("t2 rd early gnt", {15'd0, cpu_gnt}, 16'd0);
        tick();
        chk("t2 rd gnt", {15'd0, cpu_gnt}, 16'd1);
        chk("t2 rd data", {8'd0, cpu_rdata}, 16'h00A5);
        chk("t2 rd wait strobe", {15'd0, mem_read}, 16'd0);
        $display("cpu read addr=%h data=%h", cpu_addr, cpu_rdata);
        cpu_req = 1'b0;
        tick();
        chk("t2 rdata held", {8'd0, cpu_rdata}, 16'h00A5);
        chk("t2 gnt low", {15'd0, cpu_gnt}, 16'd0);

        // 3: read request and load edge in the same IDLE cycle
        fill_a(8'h40);
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0003;
        load_mem = 1'b1;
        tick();
        load_mem = 1'b0;
        run_load_a("t3", 8'h40);
        chk("t3 idle gnt", {15'd0, cpu_gnt}, 16'd0);
        tick();
        chk("t3 rd strobe", {15'd0, mem_read}, 16'd1);
        chk("t3 rd addr", mem_addr, 16'h0003);
        tick();
        chk("t3 rd gnt", {15'd0, cpu_gnt}, 16'd1);
        chk("t3 rd data", {8'd0, cpu_rdata}, 16'h0043);
        $display("cpu read addr=%h data=%h", cpu_addr, cpu_rdata);
        cpu_req = 1'b0;
        tick();

        // 4: load edge while a read is in flight
        fill_a(8'h60);
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0020;
        tick();
        chk("t4 rd strobe", {15'd0, mem_read}, 16'd1);
        load_mem = 1'b1;
        tick();
        chk("t4 rd gnt", {15'd0, cpu_gnt}, 16'd1);
        chk("t4 rd data", {8'd0, cpu_rdata}, 16'h00A5);
        chk("t4 hold", {15'd0, cpu_hold}, 16'd1);
        chk("t4 done cleared", {15'd0, load_done}, 16'd0);
        $display("cpu read addr=%h data=%h", cpu_addr, cpu_rdata);
        cpu_req = 1'b0;
        load_mem = 1'b0;
        tick();
        chk("t4 idle write", {15'd0, mem_write}, 16'd0);
        chk("t4 idle gnt", {15'd0, cpu_gnt}, 16'd0);
        chk("t4 idle hold", {15'd0, cpu_hold}, 16'd1);
        tick();
        run_load_a("t4", 8'h60);

        // 5: reset after seven load writes
        fill_a(8'h70);
        load_mem = 1'b1;
        tick();
        load_mem = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t5 addr k=%0d", k), mem_addr, 16'(k));
            tick();
        end
        chk("t5 eighth write", {15'd0, mem_write}, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5 async write", {15'd0, mem_write}, 16'd0);
        chk("t5 async addr", mem_addr, 16'd0);
        chk("t5 async data", {8'd0, mem_wdata}, 16'd0);
        chk("t5 async hold", {15'd0, cpu_hold}, 16'd0);
        chk("t5 async done", {15'd0, load_done}, 16'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("t5 quiet write c=%0d", k), {15'd0, mem_write}, 16'd0);
            chk($sformatf("t5 quiet done c=%0d", k), {15'd0, load_done}, 16'd0);
        end
        $display("load aborted by reset after 7 bytes");

        // 6: wrapped addresses, held loadMem, image changed mid-load
        for (int i = 0; i < NB; i++) image_b[i*8 +: 8] = 8'hB0 + 8'(i);
        load_mem_b = 1'b1;
        tick();
        for (int k = 0; k < NB; k++) begin
            exp_b      = 8'hB0 + 8'(k);
            exp_addr_b = 16'hFFF8 + 16'(k);
            chk($sformatf("t6 write k=%0d", k), {15'd0, mem_write_b}, 16'd1);
            chk($sformatf("t6 addr k=%0d", k), mem_addr_b, exp_addr_b);
            chk($sformatf("t6 data k=%0d", k), {8'd0, mem_wdata_b}, {8'd0, exp_b});
            if (k == 2) image_b = '1;
            tick();
        end
        chk("t6 done", {15'd0, load_done_b}, 16'd1);
        chk("t6 hold", {15'd0, cpu_hold_b}, 16'd0);
        chk("t6 gnt", {15'd0, cpu_gnt_b}, 16'd0);
        chk("t6 read", {15'd0, mem_read_b}, 16'd0);
        chk("t6 rdata", {8'd0, cpu_rdata_b}, 16'd0);
        $display("load b complete: wrapped from FFF8");
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("t6 no reload c=%0d", k), {15'd0, mem_write_b}, 16'd0);
        end
        load_mem_b = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
